mem_bus_arbiter: RTL

// - Arbitrates the shared SoC memory bus (RAM/ROM/MMIO) between two masters: M0 = debug unit, M1 = CPU data port.
// - Replaces the combinational dbg/cpu mux with a registered FSM: one transaction at a time, fixed slave read latency,
//   per-master ack and captured read data, and a CPU halt output while its access is pending.

---
 rtl/mem_bus_arbiter_if.sv | 20 ++
 rtl/mem_bus_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Per-master port bundle of the shared memory bus arbiter.
// The requesting master drives req/adr/wdata/wren; the arbiter answers with ack/rdata.
interface mem_bus_arbiter_if;
  logic        req;
  logic [31:0] adr;
  logic [31:0] wdata;
  logic [3:0]  wren;
  logic [31:0] rdata;
  logic        ack;

  modport master (
    output req, adr, wdata, wren,
    input  rdata, ack
  );

  modport slave (
    input  req, adr, wdata, wren,
    output rdata, ack
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter (M0 = debug, M1 = CPU) with a registered FSM.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; the default is fixed M0 priority.
module mem_bus_arbiter #(
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              n_reset,
  mem_bus_arbiter_if.slave  m0,
  mem_bus_arbiter_if.slave  m1,
  input  logic              m1_en,
  output logic              m1_hlt,
  output logic              s_op,
  output logic [31:0]       s_adr,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wren,
  input  logic [31:0]       s_rdata,
  output logic [1:0]        gnt
);

  localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] rd0_q, rd0_d;
  logic [31:0] rd1_q, rd1_d;
  logic        ack0, ack1;
  logic        r0, r1, win1;

`ifdef ARB_ROUND_ROBIN_EN
  logic        rr_q, rr_d;
`endif

  assign r0 = m0.req;
  assign r1 = m1.req & m1_en;

  // Pick M1 only when it requests and M0 does not claim the slot.
`ifdef ARB_ROUND_ROBIN_EN
  always_comb win1 = r1 & (~r0 | ~rr_q);
`else
  always_comb win1 = r1 & ~r0;
`endif

  // Next-state, slave-side drive and per-master completion.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    s_op    = 1'b0;
    s_adr   = '0;
    s_wdata = '0;
    s_wren  = '0;
    ack0    = 1'b0;
    ack1    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    rr_d    = rr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (r0 | r1) begin
          gnt_d   = {win1, ~win1};
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        s_op    = 1'b1;
        s_adr   = gnt_q[1] ? m1.adr   : m0.adr;
        s_wdata = gnt_q[1] ? m1.wdata : m0.wdata;
        s_wren  = gnt_q[1] ? m1.wren  : m0.wren;
        cnt_d   = CW'(RD_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          if (gnt_q[1]) rd1_d = s_rdata;
          else          rd0_d = s_rdata;
          state_d = ACK;
        end
      end
      ACK: begin
        ack0    = gnt_q[0];
        ack1    = gnt_q[1];
        gnt_d   = 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
        rr_d    = gnt_q[1];
`endif
        state_d = IDLE;
      end
    endcase
  end

  // State, grant, latency counter and captured read data.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      cnt_q   <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q    <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign m0.ack   = ack0;
  assign m1.ack   = ack1;
  assign m0.rdata = rd0_q;
  assign m1.rdata = rd1_q;
  assign gnt      = gnt_q;
  assign m1_hlt   = m1_en & m1.req & ~ack1;

endmodule
